// File: rtl/readout_holdoff_pkg.sv
// rtl/readout_holdoff_pkg.sv - shared types and defaults for the readout holdoff controller
package readout_holdoff_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLDOFF = 2'd1,
    REQ     = 2'd2
  } holdoff_state_t;

  localparam int PENDING_BITS_DEF = 4;
  localparam int HOLDOFF_BITS_DEF = 24;
  localparam int STAT_BITS_DEF    = 16;

  localparam logic [23:0] RDHOLDOFF_DEFAULT = 24'd20475;

  // holdoff_timer modes: down-counter stopping at zero, or saturating up-counter
  localparam int TMR_DOWN   = 0;
  localparam int TMR_UP_SAT = 1;

endpackage

// File: rtl/readout_holdoff_timer.sv
// rtl/readout_holdoff_timer.sv - load/step counter that stops at its terminal value
// MODE=TMR_DOWN counts down to zero; MODE=TMR_UP_SAT counts up and saturates at all-ones.
module holdoff_timer
  import readout_holdoff_pkg::*;
#(
  parameter int WIDTH = HOLDOFF_BITS_DEF,
  parameter int MODE  = TMR_DOWN
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic             term_o
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q, count_d;

  assign term_o  = (MODE == TMR_UP_SAT) ? (count_q == '1) : (count_q == '0);
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && !term_o) begin
      count_d = (MODE == TMR_UP_SAT) ? count_q + ONE : count_q - ONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/readout_holdoff_ctrl.sv
// rtl/readout_holdoff_ctrl.sv - queues triggers and issues holdoff-spaced readout requests
// Optional statistics (drop count, pending high-water mark) under READOUT_HOLDOFF_STATS_EN.
module readout_holdoff_ctrl
  import readout_holdoff_pkg::*;
#(
  parameter int PENDING_BITS = PENDING_BITS_DEF,
  parameter int HOLDOFF_BITS = HOLDOFF_BITS_DEF,
  parameter int STAT_BITS    = STAT_BITS_DEF
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [HOLDOFF_BITS-1:0] rdholdoff_i,
  input  logic                    trig_i,
  input  logic                    clr_i,
  output logic                    rd_req_o,
  input  logic                    rd_ack_i,
  output logic [PENDING_BITS-1:0] pending_o,
  output logic                    busy_o,
  output logic                    overflow_o,
  output logic [STAT_BITS-1:0]    drop_count_o,
  output logic [PENDING_BITS-1:0] pending_hwm_o
);

  localparam logic [PENDING_BITS-1:0] MAX_PENDING = '1;
  localparam logic [PENDING_BITS-1:0] PEND_ONE    = PENDING_BITS'(1);

  holdoff_state_t          state_q;
  logic                    rd_req_q;
  logic                    overflow_q;
  logic [PENDING_BITS-1:0] pending_q, pending_d;

  logic hs, full, accept, drop;
  logic timer_load, timer_zero;
  logic [HOLDOFF_BITS-1:0] timer_count_unused;

  assign hs     = rd_req_q && rd_ack_i;
  assign full   = (pending_q == MAX_PENDING);
  // A handshake in the same cycle frees a slot, so a trigger at full is still taken.
  assign accept = trig_i && (!full || hs);
  assign drop   = trig_i && full && !hs;

  always_comb begin
    pending_d = pending_q;
    if (accept && !hs) begin
      pending_d = pending_q + PEND_ONE;
    end else if (hs && !accept) begin
      pending_d = pending_q - PEND_ONE;
    end
  end

  assign timer_load = (state_q == IDLE) && (pending_q != '0);

  holdoff_timer #(
    .WIDTH (HOLDOFF_BITS),
    .MODE  (TMR_DOWN)
  ) u_holdoff_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (clr_i),
    .load_i     (timer_load),
    .load_val_i (rdholdoff_i),
    .en_i       (state_q == HOLDOFF),
    .count_o    (timer_count_unused),
    .term_o     (timer_zero)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      rd_req_q   <= 1'b0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else if (clr_i) begin
      state_q    <= IDLE;
      rd_req_q   <= 1'b0;
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      if (drop) begin
        overflow_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (pending_q != '0) begin
            state_q <= HOLDOFF;
          end
        end
        HOLDOFF: begin
          if (timer_zero) begin
            state_q  <= REQ;
            rd_req_q <= 1'b1;
          end
        end
        REQ: begin
          if (rd_ack_i) begin
            state_q  <= IDLE;
            rd_req_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          rd_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign rd_req_o   = rd_req_q;
  assign pending_o  = pending_q;
  assign busy_o     = (state_q != IDLE);
  assign overflow_o = overflow_q;

`ifdef READOUT_HOLDOFF_STATS_EN
  logic                    drop_sat;
  logic [PENDING_BITS-1:0] hwm_q;

  holdoff_timer #(
    .WIDTH (STAT_BITS),
    .MODE  (TMR_UP_SAT)
  ) u_drop_counter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (clr_i),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (drop && !drop_sat),
    .count_o    (drop_count_o),
    .term_o     (drop_sat)
  );

  // Tracks the next pending value so the mark moves in step with pending_o.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hwm_q <= '0;
    end else if (clr_i) begin
      hwm_q <= '0;
    end else if (pending_d > hwm_q) begin
      hwm_q <= pending_d;
    end
  end

  assign pending_hwm_o = hwm_q;
`else
  assign drop_count_o  = '0;
  assign pending_hwm_o = '0;
`endif

endmodule
